// File: rtl/psk_tx_pkg.sv
// Shared state and mode encodings for the PSK I/Q transmit mapper.
// Combinational definitions only; no latency or backpressure.
package psk_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2
    } state_t;

    localparam logic MODE_BPSK = 1'b0;
    localparam logic MODE_QPSK = 1'b1;

endpackage

// File: rtl/psk_iq_tx_mapper_if.sv
// Symbol-in / I-Q-sample-out bundle; slave = mapper side, master = environment side.
// No latency; valid/ready on both streams.
interface psk_iq_tx_mapper_if #(parameter int WIDTH = 16);

    logic                    mode;
    logic [1:0]              bits_tdata;
    logic                    bits_tvalid;
    logic                    bits_tready;
    logic signed [WIDTH-1:0] I_out_tdata;
    logic                    I_out_tvalid;
    logic signed [WIDTH-1:0] Q_out_tdata;
    logic                    Q_out_tvalid;
    logic                    out_tready;
    logic                    sym_start;
    logic                    busy;

    modport slave (
        input  mode, bits_tdata, bits_tvalid, out_tready,
        output bits_tready, I_out_tdata, I_out_tvalid, Q_out_tdata, Q_out_tvalid,
               sym_start, busy
    );

    modport master (
        output mode, bits_tdata, bits_tvalid, out_tready,
        input  bits_tready, I_out_tdata, I_out_tvalid, Q_out_tdata, Q_out_tvalid,
               sym_start, busy
    );

endinterface

// File: rtl/psk_symbol_map.sv
// Maps (mode, bits) to a signed I/Q constellation point of level AMP <<< SHIFT.
// Purely combinational; no backpressure.
module psk_symbol_map
    import psk_tx_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMP   = 2047,
    parameter int SHIFT = 2
) (
    input  logic                    mode_i,
    input  logic [1:0]              bits_i,
    output logic signed [WIDTH-1:0] i_o,
    output logic signed [WIDTH-1:0] q_o
);

    localparam logic signed [WIDTH-1:0] POS = WIDTH'(AMP) <<< SHIFT;
    localparam logic signed [WIDTH-1:0] NEG = -POS;

    always_comb begin
        i_o = bits_i[0] ? NEG : POS;
        q_o = '0;
        if (mode_i == MODE_QPSK) begin
            q_o = bits_i[1] ? NEG : POS;
        end
    end

endmodule

// File: rtl/psk_iq_tx_mapper.sv
// BPSK/QPSK symbol to I/Q sample stream, each point held SPS samples; first sample 1 cycle after accept,
// stalls on out_tready. Optional alternating BPSK preamble ahead of each burst with IQ_TX_PREAMBLE_EN.
module psk_iq_tx_mapper
    import psk_tx_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int SHIFT        = 2,
    parameter int AMP          = 2047,
    parameter int SPS          = 8,
    parameter int PREAMBLE_LEN = 4
) (
    input logic                clk,
    input logic                rst_n,
    psk_iq_tx_mapper_if.slave  io
);

    localparam int CW  = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int LVL = AMP * (2 ** SHIFT);

    if (LVL > (2 ** (WIDTH - 1)) - 1) begin : g_amp_chk
        $error("AMP <<< SHIFT does not fit in signed WIDTH");
    end
    if (SPS < 2) begin : g_sps_chk
        $error("SPS must be at least 2");
    end

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [WIDTH-1:0] i_q, i_d, q_q, q_d;
    logic                    vld_q, vld_d;
    logic                    sos_q, sos_d;

    logic                    rdy;
    logic                    xfer;
    logic                    last_xfer;
    logic                    accept;
    logic                    pre_last;
    logic                    pre_bit;
    logic signed [WIDTH-1:0] map_i, map_q, pre_i, pre_q;

`ifdef IQ_TX_PREAMBLE_EN
    localparam bit PRE_EN   = 1'b1;
    localparam bit IDLE_RDY = 1'b0;
    localparam int PW       = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;

    logic [PW-1:0] pcnt_q, pcnt_d;

    assign pre_last = (pcnt_q == PW'(PREAMBLE_LEN - 1));
    // Entering from IDLE always starts at +L; later symbols alternate on the next index parity.
    assign pre_bit  = (state_q == ST_IDLE) ? 1'b0 : ~pcnt_q[0];

    always_comb begin
        pcnt_d = pcnt_q;
        if (state_q == ST_IDLE) begin
            pcnt_d = '0;
        end else if (state_q == ST_PREAMBLE && last_xfer && !pre_last) begin
            pcnt_d = pcnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pcnt_q <= '0;
        else        pcnt_q <= pcnt_d;
    end
`else
    localparam bit PRE_EN   = 1'b0;
    localparam bit IDLE_RDY = 1'b1;

    assign pre_last = 1'b0;
    assign pre_bit  = 1'b0;
`endif

    psk_symbol_map #(.WIDTH(WIDTH), .AMP(AMP), .SHIFT(SHIFT)) u_map (
        .mode_i (io.mode),
        .bits_i (io.bits_tdata),
        .i_o    (map_i),
        .q_o    (map_q)
    );

    psk_symbol_map #(.WIDTH(WIDTH), .AMP(AMP), .SHIFT(SHIFT)) u_pre (
        .mode_i (MODE_BPSK),
        .bits_i ({1'b0, pre_bit}),
        .i_o    (pre_i),
        .q_o    (pre_q)
    );

    assign xfer      = vld_q && io.out_tready;
    assign last_xfer = xfer && (cnt_q == CW'(SPS - 1));
    assign accept    = io.bits_tvalid && rdy;

    always_comb begin
        rdy = 1'b0;
        case (state_q)
            ST_IDLE:     rdy = IDLE_RDY;
            ST_DATA:     rdy = last_xfer;
            ST_PREAMBLE: rdy = last_xfer && pre_last;
            default:     rdy = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        i_d     = i_q;
        q_d     = q_q;
        vld_d   = vld_q;
        sos_d   = sos_q;
        if (accept) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            i_d     = map_i;
            q_d     = map_q;
            vld_d   = 1'b1;
            sos_d   = 1'b1;
        end else if (state_q == ST_IDLE) begin
            if (PRE_EN && io.bits_tvalid) begin
                state_d = ST_PREAMBLE;
                cnt_d   = '0;
                i_d     = pre_i;
                q_d     = pre_q;
                vld_d   = 1'b1;
                sos_d   = 1'b1;
            end
        end else if (last_xfer) begin
            if (state_q == ST_PREAMBLE && !pre_last) begin
                cnt_d = '0;
                i_d   = pre_i;
                q_d   = pre_q;
                sos_d = 1'b1;
            end else begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                i_d     = '0;
                q_d     = '0;
                vld_d   = 1'b0;
                sos_d   = 1'b0;
            end
        end else if (xfer) begin
            cnt_d = cnt_q + CW'(1);
            sos_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            i_q     <= '0;
            q_q     <= '0;
            vld_q   <= 1'b0;
            sos_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            i_q     <= i_d;
            q_q     <= q_d;
            vld_q   <= vld_d;
            sos_q   <= sos_d;
        end
    end

    assign io.bits_tready  = rdy;
    assign io.I_out_tdata  = i_q;
    assign io.Q_out_tdata  = q_q;
    assign io.I_out_tvalid = vld_q;
    assign io.Q_out_tvalid = vld_q;
    assign io.sym_start    = sos_q;
    assign io.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_psk_iq_tx_mapper.sv
// Bench for psk_iq_tx_mapper: directed scenarios then random traffic, compared against a
// sample-queue reference model (each accepted symbol expands into SPS expected samples).
module tb_psk_iq_tx_mapper;

    localparam int WIDTH = 16;
    localparam int SHIFT = 2;
    localparam int AMP   = 2047;
    localparam int SPS   = 8;
    localparam int PLEN  = 4;
    localparam int L     = AMP * (2 ** SHIFT);

`ifdef IQ_TX_PREAMBLE_EN
    localparam bit IDLE_RDY = 1'b0;
`else
    localparam bit IDLE_RDY = 1'b1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    psk_iq_tx_mapper_if #(.WIDTH(WIDTH)) io ();

    psk_iq_tx_mapper #(
        .WIDTH(WIDTH), .SHIFT(SHIFT), .AMP(AMP), .SPS(SPS), .PREAMBLE_LEN(PLEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    typedef struct {
        int i;
        int q;
        bit sos;
    } samp_t;

    samp_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    bit    acc_flag = 1'b0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_sym(input bit m, input logic [1:0] b);
        int si, sq;
        si = b[0] ? -L : L;
        sq = (m == 1'b1) ? (b[1] ? -L : L) : 0;
        for (int k = 0; k < SPS; k++) exp_q.push_back('{si, sq, (k == 0)});
    endtask

    task automatic push_preamble();
        for (int p = 0; p < PLEN; p++)
            for (int k = 0; k < SPS; k++)
                exp_q.push_back('{((p % 2) == 1) ? -L : L, 0, (k == 0)});
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        int       n;
        bit       exp_rdy, xfer, acc, idle_go, m_s;
        logic [1:0] b_s;
        @(negedge clk);
        n       = exp_q.size();
        exp_rdy = (n == 0) ? IDLE_RDY : ((n == 1) && (io.out_tready === 1'b1));
        chk("i_tvalid", io.I_out_tvalid, int'(n > 0));
        chk("q_tvalid", io.Q_out_tvalid, int'(n > 0));
        chk("busy", io.busy, int'(n > 0));
        if (n > 0) begin
            chk("i_data", io.I_out_tdata, exp_q[0].i);
            chk("q_data", io.Q_out_tdata, exp_q[0].q);
            chk("sym_start", io.sym_start, int'(exp_q[0].sos));
        end else begin
            chk("i_idle", io.I_out_tdata, 0);
            chk("q_idle", io.Q_out_tdata, 0);
            chk("sym_start_idle", io.sym_start, 0);
        end
        chk("bits_tready", io.bits_tready, int'(exp_rdy));
        xfer    = rst_n && (n > 0) && io.out_tready;
        acc     = rst_n && io.bits_tvalid && exp_rdy;
        idle_go = rst_n && (n == 0) && io.bits_tvalid && !exp_rdy;
        m_s     = io.mode;
        b_s     = io.bits_tdata;
        @(posedge clk);
        acc_flag = acc;
        if (xfer) void'(exp_q.pop_front());
        if (acc) push_sym(m_s, b_s);
        else if (idle_go) push_preamble();
        #1;
    endtask

    task automatic send(input bit m, input logic [1:0] b);
        io.mode        = m;
        io.bits_tdata  = b;
        io.bits_tvalid = 1'b1;
        acc_flag       = 1'b0;
        for (int k = 0; k < 100 && !acc_flag; k++) cycle();
        io.bits_tvalid = 1'b0;
        io.bits_tdata  = 2'($urandom);
        chk("accept_within_budget", acc_flag, 1);
    endtask

    initial begin
        io.mode        = 1'b0;
        io.bits_tdata  = 2'b00;
        io.bits_tvalid = 1'b0;
        io.out_tready  = 1'b1;

        // Reset state.
        repeat (2) cycle();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle();

        // BPSK bit0=1: 8 x (-L, 0) then idle.
        send(1'b0, 2'b01);
        repeat (10) cycle();

        // QPSK 00 then 11 back-to-back with tvalid held.
        send(1'b1, 2'b00);
        send(1'b1, 2'b11);
        repeat (10) cycle();

        // Backpressure: 3 stalled cycles at sample 4.
        send(1'b1, 2'b01);
        repeat (4) cycle();
        io.out_tready = 1'b0;
        repeat (3) cycle();
        io.out_tready = 1'b1;
        repeat (8) cycle();

        // Reset at sample 4 aborts the symbol.
        send(1'b1, 2'b10);
        repeat (4) cycle();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_i", io.I_out_tdata, 0);
        chk("rst_q", io.Q_out_tdata, 0);
        chk("rst_vld", io.I_out_tvalid, 0);
        chk("rst_sos", io.sym_start, 0);
        chk("rst_busy", io.busy, 0);
        cycle();
        rst_n = 1'b1;
        repeat (3) cycle();

        // Mode change mid-symbol is ignored until the next accept.
        send(1'b0, 2'b00);
        repeat (3) cycle();
        io.mode = 1'b1;
        send(1'b1, 2'b10);
        repeat (10) cycle();

        // Random traffic with random backpressure.
        for (int k = 0; k < 600; k++) begin
            io.bits_tvalid = 1'($urandom_range(0, 1));
            io.bits_tdata  = 2'($urandom);
            io.mode        = 1'($urandom);
            io.out_tready  = ($urandom_range(0, 3) != 0);
            cycle();
        end

        io.bits_tvalid = 1'b0;
        io.out_tready  = 1'b1;
        repeat (50) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psk_iq_tx_mapper.md
Name: psk_iq_tx_mapper

Overview:
Transmit-side counterpart of the receive I/Q preprocessing ahead of Gardner timing recovery. Accepts BPSK/QPSK symbol bits over a valid/ready handshake and maps them to signed I/Q constellation points. Scales the points up by SHIFT bits, mirroring the receive-side right shift. Holds each point for SPS samples (rectangular pulse) and emits an I/Q sample stream toward the pulse-shaping filter/DAC path, with downstream backpressure.

Parameters:
WIDTH, 16, I/Q sample width (signed two's complement)
SHIFT, 2, left-shift applied to base amplitude; output level L = AMP <<< SHIFT
AMP, 2047, base constellation amplitude; L must satisfy L <= 2^(WIDTH-1)-1 (elaboration check)
SPS, 8, samples per symbol, >= 2
PREAMBLE_LEN, 4, preamble symbols (used only with IQ_TX_PREAMBLE_EN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
mode  in  1  0 = BPSK, 1 = QPSK; sampled on symbol accept
bits_tdata  in  2  symbol bits; BPSK uses bit0 only
bits_tvalid  in  1  symbol available
bits_tready  out  1  symbol accepted when tvalid && tready (combinational from state/counter/out_tready)
I_out_tdata  out  WIDTH  signed I sample
I_out_tvalid  out  1  I sample valid
Q_out_tdata  out  WIDTH  signed Q sample
Q_out_tvalid  out  1  Q sample valid; always equal to I_out_tvalid
out_tready  in  1  downstream accepts the current I/Q pair; a sample transfers when I_out_tvalid && out_tready
sym_start  out  1  high with the first sample of each symbol
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; sample counter 0; all data outputs 0; tvalid, sym_start and busy all 0. Reset mid-symbol aborts the symbol and emits no further samples.
- Mapping:
  - BPSK: bit0 = 0 -> (+L, 0); bit0 = 1 -> (-L, 0).
  - QPSK: bit0 selects the I sign and bit1 selects the Q sign (0 -> +L, 1 -> -L).
  - All arithmetic is in WIDTH-bit signed; no saturation is needed, by the parameter check.
- States: IDLE, DATA (plus PREAMBLE when the macro is defined).
- bits_tready:
  - High in IDLE.
  - High in DATA only when counter == SPS-1 && out_tready, i.e. the last sample is transferring.
  - Low otherwise.
- IDLE -> DATA on accept. The next edge registers the mapped point, sets tvalid = 1, sym_start = 1 and counter = 0. Latency from accept edge to first valid sample is 1 cycle.
- Sample advance:
  - On a transfer, counter increments; sym_start drops after the first transfer.
  - Without a transfer, all outputs hold stable.
- Symbol boundary (last sample transferring):
  - If a new symbol is accepted in the same cycle, load the new point, counter = 0, sym_start = 1. No gap between symbols.
  - Otherwise go to IDLE: tvalid = 0 and data = 0 on the next cycle.
- mode changes mid-symbol have no effect until the next accept.
- bits_tdata is ignored except on accept.

Optional Feature:
IQ_TX_PREAMBLE_EN
- Defined:
  - bits_tready is low in IDLE.
  - bits_tvalid high in IDLE -> PREAMBLE: emit PREAMBLE_LEN BPSK symbols, alternating (+L,0), (-L,0), starting +L, each SPS samples with sym_start set, under the same backpressure rules.
  - bits_tready goes high on the last sample transfer of the last preamble symbol; the boundary rules above then apply.
  - If no symbol is accepted there, return to IDLE.
- Undefined: no PREAMBLE state; behaviour exactly as above.

Decomposition:
- Package psk_tx_pkg: state encoding (IDLE/PREAMBLE/DATA), mode encoding constants (MODE_BPSK = 0, MODE_QPSK = 1).
- Sub-module psk_symbol_map: combinational (mode, bits) -> (I, Q), parameterised by WIDTH/AMP/SHIFT. Also used for preamble points.
- The top level holds the FSM, counter, handshake and output registers.

Test Plan:
Defaults throughout: L = 8188, SPS = 8.
1. BPSK bit0 = 1, out_tready = 1 -> bits_tready accept, next cycle 8 samples (-8188, 0), sym_start on the first only, then tvalid = 0 and I = Q = 0.
2. QPSK 2'b00 then 2'b11, bits_tvalid held -> 16 contiguous samples: 8 x (+8188, +8188), 8 x (-8188, -8188). Second accept occurs exactly on the 8th transfer; sym_start high at samples 0 and 8.
3. out_tready low for 3 cycles at sample 4 -> outputs and counter frozen; exactly 8 transfers per symbol; bits_tready stays low until the 8th transfer.
4. rst_n asserted at sample 4 -> all outputs 0 immediately and no further samples. After release: IDLE, bits_tready = 1 (macro undefined), busy = 0.
5. mode toggled BPSK -> QPSK at sample 3 of a BPSK symbol -> current symbol keeps Q = 0; next accepted 2'b10 yields (+8188, -8188).
6. IQ_TX_PREAMBLE_EN defined, BPSK bit 0 presented -> 32 samples alternating ±8188 in blocks of 8 starting +8188, then 8 x (+8188, 0); bits_tready low until the 32nd transfer.
